in_debounce_latch: RTL and testbench

- Front-end stage directly upstream of the CPU input module.
- Takes the raw board switch bus and the raw push-button, synchronizes both, and debounces the button.
- Captures the switch value once per clean press and holds it with a valid/read handshake toward the CPU IN path.
- Reports overrun when a new capture replaces unread data.

---
 rtl/in_port_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 34 +++
 rtl/in_debounce_latch.sv | 192 +++++++++++++++++++
 tb/tb_in_debounce_latch.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/in_port_pkg.sv
// -----------------------------------------------------------------------------
// in_port_pkg
// Shared types and constants for the switch/button input front end.
//   deb_state_t : debounce FSM states (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT)
//   IN_DATA_W   : default width of the switch bus and captured word
//   norm_btn()  : maps the raw button level onto an active-high "pressed" level
// -----------------------------------------------------------------------------
package in_port_pkg;

  localparam int IN_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

  function automatic logic norm_btn(input logic raw, input bit active_low);
    return active_low ? ~raw : raw;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for signals asynchronous to clk. Each bit is
// synchronized independently; multi-bit buses must be quasi-static while
// they are being sampled (slide switches are).
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both stages load RST_VAL
//   d     : asynchronous input
//   q     : synchronized output (two clk edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/in_debounce_latch.sv
// -----------------------------------------------------------------------------
// in_debounce_latch
// Front end upstream of the CPU IN path. Synchronizes the raw switch bus and
// push-button, debounces the button, and captures the switch value once per
// accepted press into a single holding register with a valid/read handshake.
//
// Optional feature (compile-time macro IN_AUTOREPEAT_EN): while the button is
// held in PRESSED, an extra capture is issued every REPEAT_CYCLES cycles.
// Without the macro no repeat counter exists.
//
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset, clears all state and outputs
//   switches    : raw slide switches (asynchronous)
//   button_in   : raw push-button (asynchronous, bouncing)
//   rd_en       : CPU read strobe, consumes the held word
//   data_out    : captured switch value
//   data_valid  : data_out holds an unread word
//   overrun     : sticky, an unread word was overwritten (cleared by a read)
//   press_pulse : one-cycle strobe on every capture
//
// Handshake: a word is offered while data_valid=1; it is consumed on any
// cycle where rd_en=1 and data_valid=1, and data_valid drops on the next edge
// unless a capture lands on that same edge, in which case the new word is
// offered immediately and overrun is cleared (the old word was read).
// rd_en while data_valid=0 has no effect. data_out is never cleared by reads.
// -----------------------------------------------------------------------------
module in_debounce_latch
  import in_port_pkg::*;
#(
  parameter int DATA_W         = IN_DATA_W,
  parameter int DEB_CYCLES     = 50000,
  parameter int BTN_ACTIVE_LOW = 1,
  parameter int REPEAT_CYCLES  = 25000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] switches,
  input  logic              button_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              overrun,
  output logic              press_pulse
);

  localparam int              CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  // Button synchronizer resets to the idle (released) raw level so that
  // leaving reset never looks like a press.
  localparam logic            BTN_IDLE = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  generate
    if (DEB_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_param
      $error("in_debounce_latch: DEB_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Synchronization
  // ---------------------------------------------------------------------------
  logic              btn_sync;
  logic              btn_s;
  logic [DATA_W-1:0] sw_s;

  sync_2ff #(.W(1), .RST_VAL(BTN_IDLE)) u_sync_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (button_in),
    .q     (btn_sync)
  );

  sync_2ff #(.W(DATA_W), .RST_VAL('0)) u_sync_sw (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (switches),
    .q     (sw_s)
  );

  assign btn_s = norm_btn(btn_sync, BTN_ACTIVE_LOW != 0);

  // ---------------------------------------------------------------------------
  // Debounce FSM. cnt restarts on every state change; the wait states leave
  // on cnt==CNT_LAST so cnt never wraps.
  // ---------------------------------------------------------------------------
  deb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             cap_press;
  logic             cap_rpt;
  logic             capture;

  assign cap_press = (state == PRESS_WAIT) && btn_s && (cnt == CNT_LAST);

`ifdef IN_AUTOREPEAT_EN
  localparam int              RPT_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] rpt;

  // Counts cycles spent holding in PRESSED; anything else restarts it, so the
  // first repeat lands REPEAT_CYCLES after the initial capture.
  assign cap_rpt = (state == PRESSED) && btn_s && (rpt == RPT_LAST);
`else
  assign cap_rpt = 1'b0;
`endif

  assign capture = cap_press | cap_rpt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
`ifdef IN_AUTOREPEAT_EN
      rpt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= PRESSED;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            // Bounce during release: back to held, no new capture.
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

`ifdef IN_AUTOREPEAT_EN
      if (state == PRESSED && btn_s) begin
        rpt <= (rpt == RPT_LAST) ? '0 : rpt + 1'b1;
      end else begin
        rpt <= '0;
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Holding register and handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      overrun     <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= capture;
      if (capture) begin
        data_out   <= sw_s;
        data_valid <= 1'b1;
        // Overwriting an unread word is an overrun unless it is read on this
        // very edge; with nothing held, overrun is already 0.
        overrun    <= data_valid && !rd_en;
      end else if (rd_en && data_valid) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_in_debounce_latch.sv
// -----------------------------------------------------------------------------
// tb_in_debounce_latch
// Directed scenarios with literal expectations plus a randomized run, all
// checked every cycle against a run-length model of the debounce rules.
// Build with +define+IN_AUTOREPEAT_EN to exercise the auto-repeat variant.
// -----------------------------------------------------------------------------
module tb_in_debounce_latch;

  localparam int DATA_W = 16;
  localparam int DEB    = 4;
  localparam int REP    = 10;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [DATA_W-1:0] switches = '0;
  logic              button_in = 1'b1;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              overrun;
  logic              press_pulse;

  always #5 clk = ~clk;

  in_debounce_latch #(
    .DATA_W         (DATA_W),
    .DEB_CYCLES     (DEB),
    .BTN_ACTIVE_LOW (1),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .switches    (switches),
    .button_in   (button_in),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .overrun     (overrun),
    .press_pulse (press_pulse)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: the button is seen two edges late; a press is accepted
  // when DEB+1 consecutive pressed samples are seen while released, and a
  // release when DEB+1 consecutive released samples are seen while pressed.
  // ---------------------------------------------------------------------------
  logic              r_d1, r_d2;
  logic [DATA_W-1:0] s_d1, s_d2;
  bit                m_pressed;
  int                m_run;
  int                m_since;
  logic [DATA_W-1:0] e_data;
  logic              e_valid, e_ovr, e_pulse;

  task automatic model_reset();
    r_d1 = 1'b1; r_d2 = 1'b1;
    s_d1 = '0;   s_d2 = '0;
    m_pressed = 1'b0; m_run = 0; m_since = 0;
    e_data = '0; e_valid = 1'b0; e_ovr = 1'b0; e_pulse = 1'b0;
  endtask

  task automatic model_step();
    logic              b;
    logic [DATA_W-1:0] sw;
    bit                cap;
    int                prev;
    b    = ~r_d2;
    sw   = s_d2;
    r_d2 = r_d1; r_d1 = button_in;
    s_d2 = s_d1; s_d1 = switches;
    cap  = 1'b0;
    prev = m_run;
    if (!m_pressed) begin
      m_run = b ? m_run + 1 : 0;
      if (m_run == DEB + 1) begin
        cap = 1'b1; m_pressed = 1'b1; m_run = 0; m_since = 0;
      end
    end else begin
      m_run = !b ? m_run + 1 : 0;
`ifdef IN_AUTOREPEAT_EN
      if (b && prev == 0) begin
        m_since++;
        if (m_since == REP) begin
          cap = 1'b1; m_since = 0;
        end
      end else if (b) begin
        m_since = 0;
      end
`endif
      if (m_run == DEB + 1) begin
        m_pressed = 1'b0; m_run = 0;
      end
    end
    if (prev < 0) cap = 1'b0;
    e_pulse = cap;
    if (cap) begin
      e_ovr   = e_valid && !rd_en;
      e_data  = sw;
      e_valid = 1'b1;
    end else if (rd_en && e_valid) begin
      e_valid = 1'b0;
      e_ovr   = 1'b0;
    end
  endtask

  initial begin : model
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Compare process: outputs are registered, so sample on the falling edge.
  initial begin : compare
    forever begin
      @(negedge clk);
      check("cyc_data_out",    32'(data_out),    32'(e_data));
      check("cyc_data_valid",  32'(data_valid),  32'(e_valid));
      check("cyc_overrun",     32'(overrun),     32'(e_ovr));
      check("cyc_press_pulse", 32'(press_pulse), 32'(e_pulse));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  int edge_i;
  int pulse_q[$];

  task automatic start_seq();
    edge_i = 0;
    pulse_q.delete();
  endtask

  // One clock: drive on the falling edge, sample #1 after the rising edge.
  task automatic cyc(input logic b, input logic [DATA_W-1:0] sw, input logic rd);
    @(negedge clk);
    button_in = b;
    switches  = sw;
    rd_en     = rd;
    @(posedge clk);
    #1;
    edge_i++;
    if (press_pulse === 1'b1) pulse_q.push_back(edge_i);
  endtask

  // Press for 'hold' cycles then release for 'rel' cycles; rd_en on edge rd_at.
  task automatic press(input logic [DATA_W-1:0] sw, input int hold, input int rel, input int rd_at);
    start_seq();
    for (int i = 1; i <= hold + rel; i++) cyc((i <= hold) ? 1'b0 : 1'b1, sw, (i == rd_at));
  endtask

  task automatic check_first_pulse(input string name, input int exp_edge);
    if (pulse_q.size() > 0) check(name, 32'(pulse_q[0]), 32'(exp_edge));
    else                    check(name, 32'hFFFF_FFFF, 32'(exp_edge));
  endtask

  task automatic async_reset(input int cycles);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_data_out",    32'(data_out),    32'h0);
    check("rst_data_valid",  32'(data_valid),  32'h0);
    check("rst_overrun",     32'(overrun),     32'h0);
    check("rst_press_pulse", 32'(press_pulse), 32'h0);
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int exp_rep[$];

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    int run_len;
    logic b;
    logic [DATA_W-1:0] sw;

    // Reset between clock edges, from a fresh start.
    #2;
    rst_n = 1'b0;
    #1;
    check("init_data_valid", 32'(data_valid), 32'h0);
    check("init_overrun",    32'(overrun),    32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc(1'b1, 16'h0000, 1'b0);

    // Clean press: capture at edge 7, nothing on release.
    press(16'hA5C3, 20, 15, 0);
`ifdef IN_AUTOREPEAT_EN
    check("clean_pulse_count", 32'(pulse_q.size()), 32'd2);
`else
    check("clean_pulse_count", 32'(pulse_q.size()), 32'd1);
`endif
    check_first_pulse("clean_pulse_edge", 7);
    check("clean_data_out",   32'(data_out),   32'h0000_A5C3);
    check("clean_data_valid", 32'(data_valid), 32'h1);

    // Reset while holding unread data discards it.
    async_reset(2);
    repeat (3) cyc(1'b1, 16'h0000, 1'b0);

    // Bounce: low/high every 2 cycles for 12 cycles, then high.
    start_seq();
    for (int i = 1; i <= 30; i++) cyc((i <= 12 && ((i - 1) / 2) % 2 == 0) ? 1'b0 : 1'b1, 16'h1234, 1'b0);
    check("bounce_pulse_count", 32'(pulse_q.size()), 32'd0);
    check("bounce_data_valid",  32'(data_valid),     32'h0);

    // Overrun: two presses without a read, then a read.
    press(16'h0001, 10, 10, 0);
    check_first_pulse("ovr_first_edge", 7);
    press(16'h0002, 10, 10, 0);
    check("ovr_data_out",   32'(data_out),   32'h0000_0002);
    check("ovr_overrun",    32'(overrun),    32'h1);
    check("ovr_data_valid", 32'(data_valid), 32'h1);
    cyc(1'b1, 16'h0002, 1'b1);
    check("read_data_valid", 32'(data_valid), 32'h0);
    check("read_overrun",    32'(overrun),    32'h0);
    check("read_data_keep",  32'(data_out),   32'h0000_0002);
    cyc(1'b1, 16'h0002, 1'b1);
    check("idle_read_valid", 32'(data_valid), 32'h0);

    // Capture and read on the same edge.
    press(16'h0004, 10, 10, 0);
    press(16'h0005, 10, 10, 7);
    check_first_pulse("simul_edge", 7);
    check("simul_data_out",   32'(data_out),   32'h0000_0005);
    check("simul_data_valid", 32'(data_valid), 32'h1);
    check("simul_overrun",    32'(overrun),    32'h0);
    cyc(1'b1, 16'h0005, 1'b1);

    // Long hold: repeats only with the macro.
`ifdef IN_AUTOREPEAT_EN
    exp_rep = '{7, 17, 27, 37};
`else
    exp_rep = '{7};
`endif
    press(16'hBEEF, 40, 15, 0);
    check("hold_pulse_count", 32'(pulse_q.size()), 32'(exp_rep.size()));
    for (int i = 0; i < exp_rep.size(); i++) begin
      if (i < pulse_q.size()) check("hold_pulse_edge", 32'(pulse_q[i]), 32'(exp_rep[i]));
      else                    check("hold_pulse_edge", 32'hFFFF_FFFF, 32'(exp_rep[i]));
    end
    check("hold_data_out", 32'(data_out), 32'h0000_BEEF);

    // Randomized runs of pressed/released levels, random reads and switches.
    sw = 16'(($urandom));
    b  = 1'b1;
    for (int k = 0; k < 300; k++) begin
      run_len = $urandom_range(1, 14);
      b = ~b;
      if ($urandom_range(0, 2) == 0) sw = 16'($urandom);
      for (int j = 0; j < run_len; j++) cyc(b, sw, ($urandom_range(0, 3) == 0));
      if (k == 150) async_reset(1);
    end
    repeat (20) cyc(1'b1, sw, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
